// File: rtl/led_scan_controller_pkg.sv
// Shared state encoding, default panel geometry and elaboration helpers
// for the LED scan controller.
package led_scan_controller_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BLANK,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_HOLD,
        ST_BRIGHT_LOAD,
        ST_BRIGHT_SHIFT,
        ST_BRIGHT_LATCH
    } scan_state_e;

    localparam int DEF_ROWS             = 16;
    localparam int DEF_PWM_BITS         = 8;
    localparam int DEF_SHIFT_LEN        = 32;
    localparam int DEF_BLANK_CYCLES     = 8;
    localparam int DEF_BRIGHT_SHIFT_LEN = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_scan_controller_slot_shifter.sv
// LOAD/SHIFT/LATCH strobe engine. Driven by the frame FSM's next state so
// that its registered strobes line up with the FSM's registered outputs.
module led_scan_controller_slot_shifter #(
    parameter int MAX_BITS = 32,
    localparam int BIT_W   = $clog2(MAX_BITS + 1),
    localparam int CNT_W   = BIT_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             latch,
    input  logic             mode,
    input  logic [BIT_W-1:0] bit_count,
    output logic             done,
    output logic             load_led_vals,
    output logic             load_brightness,
    output logic             serial_clk,
    output logic             shift,
    output logic             latch_enable
);

    logic [BIT_W-1:0] bits_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_idx;
    logic [CNT_W-1:0] last_idx;
    logic             shifting;

    // Each bit takes two cycles, so the last shift cycle index is 2*bits-1.
    assign last_idx = {bits_q, 1'b0} - CNT_W'(1);
    assign done     = shifting && (cnt == last_idx);
    assign nxt_idx  = shifting ? cnt + CNT_W'(1) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            bits_q          <= '0;
            cnt             <= '0;
            shifting        <= 1'b0;
            load_led_vals   <= 1'b0;
            load_brightness <= 1'b0;
            serial_clk      <= 1'b0;
            shift           <= 1'b0;
            latch_enable    <= 1'b0;
        end else begin
            if (start) begin
                bits_q <= bit_count;
            end
            if (run) begin
                cnt <= nxt_idx;
            end
            shifting        <= run;
            load_led_vals   <= start & ~mode;
            load_brightness <= start & mode;
            // Odd cycle of each bit pair carries the rising shift clock.
            serial_clk      <= run & nxt_idx[0];
            shift           <= run & nxt_idx[0];
            latch_enable    <= latch;
        end
    end

endmodule

// File: rtl/led_scan_controller.sv
// Scan/timing generator for LED cube panels: row, PWM-slot and blanking
// sequencing, brightness pass, enable/idle control and frame-synchronous swap.
module led_scan_controller
    import led_scan_controller_pkg::*;
#(
    parameter int ROWS             = DEF_ROWS,
    parameter int PWM_BITS         = DEF_PWM_BITS,
    parameter int SHIFT_LEN        = DEF_SHIFT_LEN,
    parameter int BLANK_CYCLES     = DEF_BLANK_CYCLES,
    parameter int BRIGHT_SHIFT_LEN = DEF_BRIGHT_SHIFT_LEN,
    parameter bit BRIGHTNESS_EN    = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     swap_req,
    output logic                     serial_clk,
    output logic                     latch_enable,
    output logic                     output_enable_n,
    output logic [ROWS-1:0]          row_select_n,
    output logic                     shift,
    output logic                     load_led_vals,
    output logic                     load_brightness,
    output logic                     special_mode,
    output logic [PWM_BITS-1:0]      pwm_time,
    output logic [$clog2(ROWS)-1:0]  active_row_addr,
    output logic                     buffer_select,
    output logic                     frame_start,
    output logic                     swap_ack
);

    localparam int ROW_W       = $clog2(ROWS);
    localparam int HOLD_CYCLES = 2 * SHIFT_LEN;
    localparam int CNT_W       = $clog2(max_int(BLANK_CYCLES, HOLD_CYCLES) + 1);
    localparam int MAX_BITS    = max_int(SHIFT_LEN, BRIGHT_SHIFT_LEN);
    localparam int BIT_W       = $clog2(MAX_BITS + 1);

    localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
    localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]    HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

    scan_state_e         state, nxt_state;
    logic [CNT_W-1:0]    cnt, nxt_cnt;
    logic [PWM_BITS-1:0] nxt_pwm;
    logic [ROW_W-1:0]    nxt_row;
    logic                swap_pending;
    logic                frame_end, start_frame, take_swap;
    logic                nxt_lit, nxt_bright;
    logic                eng_start, eng_run, eng_latch, eng_mode, eng_done;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_pwm     = pwm_time;
        nxt_row     = active_row_addr;
        frame_end   = 1'b0;
        start_frame = 1'b0;

        case (state)
            ST_IDLE: begin
                start_frame = enable;
            end
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    nxt_state = ST_LOAD;
                    nxt_pwm   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            ST_LOAD:  nxt_state = ST_SHIFT;
            ST_SHIFT: if (eng_done) nxt_state = ST_LATCH;
            ST_LATCH: begin
                if (pwm_time != PWM_MAX) begin
                    nxt_state = ST_LOAD;
                    nxt_pwm   = pwm_time + PWM_BITS'(1);
                end else begin
                    nxt_state = ST_HOLD;
                    nxt_cnt   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt != HOLD_LAST) begin
                    nxt_cnt = cnt + CNT_W'(1);
                end else if (active_row_addr != ROW_LAST) begin
                    nxt_state = ST_BLANK;
                    nxt_row   = active_row_addr + ROW_W'(1);
                    nxt_cnt   = '0;
                end else if (BRIGHTNESS_EN) begin
                    nxt_state = ST_BRIGHT_LOAD;
                end else begin
                    frame_end = 1'b1;
                end
            end
            ST_BRIGHT_LOAD:  nxt_state = ST_BRIGHT_SHIFT;
            ST_BRIGHT_SHIFT: if (eng_done) nxt_state = ST_BRIGHT_LATCH;
            ST_BRIGHT_LATCH: frame_end = 1'b1;
            default:         nxt_state = ST_IDLE;
        endcase

        // enable is only consulted here, so a mid-frame drop lets the frame finish.
        if (frame_end) begin
            if (enable) begin
                start_frame = 1'b1;
            end else begin
                nxt_state = ST_IDLE;
            end
        end
        if (start_frame) begin
            nxt_state = ST_BLANK;
            nxt_row   = '0;
            nxt_cnt   = '0;
        end

        take_swap = (frame_end || state == ST_IDLE) && (swap_pending || swap_req);
    end

    // Outputs are decoded from the next state so they register alongside it.
    assign nxt_bright = nxt_state inside {ST_BRIGHT_LOAD, ST_BRIGHT_SHIFT, ST_BRIGHT_LATCH};
    assign nxt_lit    = ((nxt_state == ST_LOAD || nxt_state == ST_SHIFT) && nxt_pwm != '0)
                        || nxt_state == ST_HOLD;
    assign eng_start  = nxt_state == ST_LOAD  || nxt_state == ST_BRIGHT_LOAD;
    assign eng_run    = nxt_state == ST_SHIFT || nxt_state == ST_BRIGHT_SHIFT;
    assign eng_latch  = nxt_state == ST_LATCH || nxt_state == ST_BRIGHT_LATCH;
    assign eng_mode   = nxt_state == ST_BRIGHT_LOAD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            pwm_time        <= '0;
            active_row_addr <= '0;
            swap_pending    <= 1'b0;
            buffer_select   <= 1'b0;
            frame_start     <= 1'b0;
            swap_ack        <= 1'b0;
            special_mode    <= 1'b0;
            output_enable_n <= 1'b1;
            row_select_n    <= '1;
        end else begin
            state           <= nxt_state;
            cnt             <= nxt_cnt;
            pwm_time        <= nxt_pwm;
            active_row_addr <= nxt_row;
            swap_pending    <= take_swap ? 1'b0 : (swap_pending | swap_req);
            if (take_swap) begin
                buffer_select <= ~buffer_select;
            end
            frame_start     <= start_frame;
            swap_ack        <= take_swap;
            special_mode    <= nxt_bright;
            output_enable_n <= ~nxt_lit;
            row_select_n    <= nxt_lit ? ~(ROWS'(1) << nxt_row) : '1;
        end
    end

    led_scan_controller_slot_shifter #(
        .MAX_BITS (MAX_BITS)
    ) u_slot_shifter (
        .clk             (clk),
        .reset           (reset),
        .start           (eng_start),
        .run             (eng_run),
        .latch           (eng_latch),
        .mode            (eng_mode),
        .bit_count       (eng_mode ? BIT_W'(BRIGHT_SHIFT_LEN) : BIT_W'(SHIFT_LEN)),
        .done            (eng_done),
        .load_led_vals   (load_led_vals),
        .load_brightness (load_brightness),
        .serial_clk      (serial_clk),
        .shift           (shift),
        .latch_enable    (latch_enable)
    );

endmodule

// File: tb/tb_led_scan_controller.sv
// Self-checking bench for led_scan_controller: every cycle is compared with a
// frame-position model derived from the scan geometry rules.
module tb_led_scan_controller;

    localparam int ROWS      = 2;
    localparam int PWM_BITS  = 2;
    localparam int SHIFT_LEN = 4;
    localparam int BLANK     = 3;
    localparam int BSHIFT    = 4;
    localparam int SLOTS     = 1 << PWM_BITS;
    localparam int SLOT_LEN  = 2 * SHIFT_LEN + 2;
    localparam int BSLOT_LEN = 2 * BSHIFT + 2;
    localparam int HOLD      = 2 * SHIFT_LEN;
    localparam int ROW_LEN   = BLANK + SLOTS * SLOT_LEN + HOLD;
    localparam int FRAME_LEN = ROWS * ROW_LEN + BSLOT_LEN;

    typedef struct packed {
        logic       sclk;
        logic       le;
        logic       oe_n;
        logic [1:0] rs;
        logic       sh;
        logic       lled;
        logic       lbr;
        logic       sm;
        logic [1:0] pwm;
        logic       row;
        logic       bsel;
        logic       fs;
        logic       ack;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset, enable, swap_req;
    logic       serial_clk, latch_enable, output_enable_n, shift;
    logic       load_led_vals, load_brightness, special_mode;
    logic [1:0] row_select_n, pwm_time;
    logic       active_row_addr, buffer_select, frame_start, swap_ack;

    int   total = 0;
    int   bad   = 0;
    logic mdl_run  = 1'b0;
    int   mdl_p    = 0;
    logic bsel_exp = 1'b0;
    logic pend     = 1'b0;
    logic ack_exp  = 1'b0;

    led_scan_controller #(
        .ROWS             (ROWS),
        .PWM_BITS         (PWM_BITS),
        .SHIFT_LEN        (SHIFT_LEN),
        .BLANK_CYCLES     (BLANK),
        .BRIGHT_SHIFT_LEN (BSHIFT),
        .BRIGHTNESS_EN    (1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .swap_req        (swap_req),
        .serial_clk      (serial_clk),
        .latch_enable    (latch_enable),
        .output_enable_n (output_enable_n),
        .row_select_n    (row_select_n),
        .shift           (shift),
        .load_led_vals   (load_led_vals),
        .load_brightness (load_brightness),
        .special_mode    (special_mode),
        .pwm_time        (pwm_time),
        .active_row_addr (active_row_addr),
        .buffer_select   (buffer_select),
        .frame_start     (frame_start),
        .swap_ack        (swap_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs at position p of a running frame (p=0 is the frame_start cycle).
    function automatic outs_t expect_run(input int p, output logic chk_pwm, output logic chk_row);
        outs_t e;
        int q, r, s;
        e = '0;
        e.oe_n  = 1'b1;
        chk_pwm = 1'b0;
        chk_row = 1'b0;
        if (p < ROWS * ROW_LEN) begin
            e.row   = 1'(p / ROW_LEN);
            chk_row = 1'b1;
            q = p % ROW_LEN;
            if (q >= BLANK && q < BLANK + SLOTS * SLOT_LEN) begin
                s = (q - BLANK) / SLOT_LEN;
                r = (q - BLANK) % SLOT_LEN;
                e.pwm   = 2'(s);
                chk_pwm = 1'b1;
                e.lled  = (r == 0);
                e.le    = (r == SLOT_LEN - 1);
                if (r > 0 && r < SLOT_LEN - 1) begin
                    e.sclk = ((r - 1) % 2 == 1);
                    e.sh   = e.sclk;
                end
                e.oe_n = (s == 0) || (r == SLOT_LEN - 1);
            end else if (q >= BLANK + SLOTS * SLOT_LEN) begin
                e.pwm   = 2'(SLOTS - 1);
                chk_pwm = 1'b1;
                e.oe_n  = 1'b0;
            end
        end else begin
            r = p - ROWS * ROW_LEN;
            e.sm  = 1'b1;
            e.lbr = (r == 0);
            e.le  = (r == BSLOT_LEN - 1);
            if (r > 0 && r < BSLOT_LEN - 1) begin
                e.sclk = ((r - 1) % 2 == 1);
                e.sh   = e.sclk;
            end
        end
        e.rs = e.oe_n ? 2'b11 : ~(2'b01 << e.row);
        e.fs = (p == 0);
        return e;
    endfunction

    // Compare the current cycle, drive this cycle's inputs, advance the model one clock.
    task automatic cycle(input logic en, input logic req);
        outs_t exp_o, obs_o;
        logic  chk_pwm, chk_row, take;
        if (mdl_run) begin
            exp_o = expect_run(mdl_p, chk_pwm, chk_row);
        end else begin
            exp_o      = '0;
            exp_o.oe_n = 1'b1;
            exp_o.rs   = 2'b11;
            chk_pwm    = 1'b0;
            chk_row    = 1'b0;
        end
        exp_o.bsel = bsel_exp;
        exp_o.ack  = ack_exp;
        obs_o = {serial_clk, latch_enable, output_enable_n, row_select_n, shift,
                 load_led_vals, load_brightness, special_mode, pwm_time,
                 active_row_addr, buffer_select, frame_start, swap_ack};
        if (!chk_pwm) begin
            obs_o.pwm = '0;
            exp_o.pwm = '0;
        end
        if (!chk_row) begin
            obs_o.row = 1'b0;
            exp_o.row = 1'b0;
        end
        check($sformatf("%s p=%0d", mdl_run ? "scan" : "idle", mdl_p), 32'(obs_o), 32'(exp_o));

        enable   = en;
        swap_req = req;
        if (mdl_run) begin
            take = (mdl_p == FRAME_LEN - 1) && (pend || req);
            if (mdl_p == FRAME_LEN - 1) begin
                mdl_p   = 0;
                mdl_run = en;
            end else begin
                mdl_p++;
            end
        end else begin
            take = pend || req;
            if (en) begin
                mdl_run = 1'b1;
                mdl_p   = 0;
            end
        end
        pend = take ? 1'b0 : (pend | req);
        if (take) bsel_exp = ~bsel_exp;
        ack_exp = take;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        swap_req = 1'b0;
        @(negedge clk);
        check("rst oe_n", 32'(output_enable_n), 32'd1);
        check("rst row_select_n", 32'(row_select_n), 32'h3);
        check("rst strobes", 32'({serial_clk, latch_enable, shift, load_led_vals,
              load_brightness, special_mode, frame_start, swap_ack}), 32'd0);
        check("rst buffer_select", 32'(buffer_select), 32'd0);
        check("rst pwm_time", 32'(pwm_time), 32'd0);
        check("rst active_row_addr", 32'(active_row_addr), 32'd0);
        mdl_run  = 1'b0;
        mdl_p    = 0;
        bsel_exp = 1'b0;
        pend     = 1'b0;
        ack_exp  = 1'b0;
        reset    = 1'b0;
    endtask

    initial begin
        int r1, r2, stop;
        reset    = 1'b1;
        enable   = 1'b1;
        swap_req = 1'b0;
        repeat (3) @(negedge clk);
        apply_reset();

        // Frame 1: single swap request at cycle 20.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < FRAME_LEN; i++) cycle(1'b1, i == 20);

        // Frame 2: two requests collapse into one toggle.
        r1 = int'($urandom_range(0, 50));
        r2 = int'($urandom_range(51, FRAME_LEN - 2));
        for (int i = 0; i < FRAME_LEN; i++) cycle(1'b1, i == r1 || i == r2);

        // Frame 3: sparse random requests plus one on the frame-end cycle itself.
        for (int i = 0; i < FRAME_LEN; i++)
            cycle(1'b1, (i == FRAME_LEN - 1) || ($urandom_range(0, 29) == 0));

        // Frame 4: enable drops mid-frame; the frame still completes, then IDLE.
        stop = int'($urandom_range(5, 100));
        for (int i = 0; i < FRAME_LEN; i++) cycle(i < stop, 1'b0);
        repeat (4) cycle(1'b0, 1'b0);

        // Swap requests in IDLE are taken immediately.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        if (bsel_exp == 1'b0) begin
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b0);
        end

        // Restart, leave a swap pending, then reset in the middle of SHIFT.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, i == 2);
        apply_reset();

        // The pending swap must have been discarded: no ack at the next frame start.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < FRAME_LEN + 5; i++) cycle(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
